// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and dispatch helper for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LUI = 4'b0011;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    // Widest datapath the dispatch helper can classify.
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    // True when the op needs iterations: SRA with a nonzero shift amount, or MUL
    // (when built) with a nonzero multiplier. src2 arrives zero-extended.
    function automatic logic is_multicycle(input logic [3:0]           op,
                                           input logic [MAX_WIDTH-1:0] src2,
                                           input int unsigned          width,
                                           input logic                 mul_en);
        logic [MAX_WIDTH-1:0] shamt_mask;
        logic                 multi;
        shamt_mask = MAX_WIDTH'(width - 1);
        multi      = 1'b0;
        case (op)
            OP_SRA:  multi = (src2 & shamt_mask) != '0;
            OP_MUL:  multi = mul_en && (src2 != '0);
            default: multi = 1'b0;
        endcase
        return multi;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH iterations,
// product truncated to WIDTH bits.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_step;
    logic [CW-1:0]    cnt_q;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy     = cnt_q != '0;
    // done flags the final iteration; product already includes that step so the
    // caller can capture it on the same edge.
    assign done     = busy && (cnt_q == CW'(1));
    assign product  = acc_step;

    // Operand load on start, then one shift-add step per busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
        end else if (busy) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative SRA and
// optional iterative MUL, with registered result and status flags.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1,
    parameter int unsigned SHW    = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             illegal_o
);

    state_e           state_q;
    state_e           state_d;
    logic             accept;
    logic             multi;
    logic [SHW-1:0]   shamt;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;
    logic             sc_illegal;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] sra_q;
    logic [WIDTH-1:0] sra_next;
    logic [SHW-1:0]   sra_cnt_q;
    logic             sra_last;

    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic             busy_done;
    logic [WIDTH-1:0] busy_result;

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             illegal_q;

    assign accept    = valid_i && ready_o;
    assign shamt     = src2_i[SHW-1:0];
    assign multi     = is_multicycle(ctrl_i, MAX_WIDTH'(src2_i), WIDTH, MUL_EN);
    assign sum       = src1_i + src2_i;
    assign diff      = src1_i - src2_i;

    assign sra_next  = $signed(sra_q) >>> 1;
    assign sra_last  = (state_q == S_BUSY) && (op_q == OP_SRA) && (sra_cnt_q == SHW'(1));
    assign mul_start = accept && multi && (ctrl_i == OP_MUL);

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk     (clk_i),
                .rst     (rst_i),
                .start   (mul_start),
                .a       (src1_i),
                .b       (src2_i),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign busy_done   = sra_last || (mul_busy && mul_done);
    assign busy_result = (op_q == OP_SRA) ? sra_next : mul_product;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = multi ? S_BUSY : S_DONE;
            S_BUSY:  if (busy_done) state_d = S_DONE;
            S_DONE:  if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs; ready is held low while reset is applied.
    always_comb begin
        ready_o = (state_q == S_IDLE) && !rst_i;
        valid_o = (state_q == S_DONE);
    end

    // Single-cycle ops. SRA and MUL only land here in their trivial cases
    // (shamt == 0 gives src1, src2 == 0 gives 0).
    always_comb begin
        sc_result  = '0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        case (ctrl_i)
            OP_AND: sc_result = src1_i & src2_i;
            OP_OR:  sc_result = src1_i | src2_i;
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                            (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                            (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT: sc_result[0] = $signed(src1_i) < $signed(src2_i);
            OP_LUI: sc_result = src2_i << (WIDTH / 2);
            OP_SRA: sc_result = src1_i;
            OP_MUL: sc_illegal = !MUL_EN;
            default: sc_illegal = 1'b1;
        endcase
    end

    // Operand capture, SRA iteration and registered result/flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= OP_AND;
            sra_q     <= '0;
            sra_cnt_q <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            op_q      <= ctrl_i;
            sra_q     <= src1_i;
            sra_cnt_q <= shamt;
            if (!multi) begin
                result_q  <= sc_result;
                zero_q    <= sc_result == '0;
                ovf_q     <= sc_ovf;
                illegal_q <= sc_illegal;
            end
        end else if (state_q == S_BUSY) begin
            if (op_q == OP_SRA) begin
                sra_q     <= sra_next;
                sra_cnt_q <= sra_cnt_q - SHW'(1);
            end
            if (busy_done) begin
                result_q  <= busy_result;
                zero_q    <= busy_result == '0;
                ovf_q     <= 1'b0;
                illegal_q <= 1'b0;
            end
        end
    end

    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign ovf_o     = ovf_q;
    assign illegal_o = illegal_q;

endmodule
